// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: funct3 encodings, writeback FSM states and the
// byte-enable / alignment helpers also used by the EX stage address logic.
package pipe_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_LOAD_WAIT
    } wb_state_e;

    // Stores have no unsigned variants, so 100/101 are no-ops for them as well.
    function automatic logic size_ok(input logic [2:0] f3, input logic is_store);
        case (f3)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !is_store;
            default:                size_ok = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] data);
        case (f3[1:0])
            2'b00:   store_rep = {4{data[7:0]}};
            2'b01:   store_rep = {2{data[15:0]}};
            default: store_rep = data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half at the access offset out of the
// returned word and sign- or zero-extends it according to funct3.
module load_align
    import pipe_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Writeback stage: ALU writeback, dmem load/store handshake and stall control.
// Optional dmem wait timeout with bus_error pulse when WB_TIMEOUT_EN is defined.
module mem_writeback
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_result,
    input  logic [31:0] wb_store_data,
    input  logic        wb_mem_write,
    input  logic        wb_mem_to_reg,
    input  logic        wb_alu_to_reg,
    input  logic [4:0]  wb_dest_reg_sel,
    input  logic        wb_branch_nxt,
    input  logic [1:0]  wb_read_address,
    input  logic [2:0]  mem_alu_operation,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_read,
    output logic        misaligned,
    output logic        bus_error
);

    wb_state_e   state;
    logic        skip;
    logic [4:0]  rd_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] load_data;
    logic        live, mem_op, idle_mem, mis, start, handshake, timeout;
    logic        unused_addr_lo;

    assign unused_addr_lo = ^wb_result[1:0];

    assign live      = reset && !wb_branch_nxt;
    assign mem_op    = wb_mem_write || wb_mem_to_reg;
    // skip masks the finished instruction still held on wb_* for one cycle
    // after a store acceptance or a timeout abort.
    assign idle_mem  = live && (state == S_IDLE) && !skip && mem_op &&
                       size_ok(mem_alu_operation, wb_mem_write);
    assign mis       = idle_mem && is_misaligned(mem_alu_operation, wb_read_address);
    assign start     = idle_mem && !mis;
    assign handshake = ((state == S_REQ) && dmem_ready) ||
                       ((state == S_LOAD_WAIT) && dmem_rvalid);

`ifdef WB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wait_cnt;

    assign timeout = (state != S_IDLE) && !handshake &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Cleared while idle and on REQ->LOAD_WAIT, so each wait state counts from 0.
    always_ff @(posedge clk) begin
        if (!reset || state == S_IDLE || (state == S_REQ && dmem_ready))
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) bus_error <= 1'b0;
        else        bus_error <= timeout;
    end
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            skip       <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            rd_q       <= '0;
            off_q      <= '0;
            f3_q       <= '0;
        end else begin
            skip <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= wb_mem_write;
                        dmem_addr  <= {wb_result[31:2], 2'b00};
                        dmem_wdata <= wb_mem_write ? store_rep(mem_alu_operation, wb_store_data) : '0;
                        dmem_be    <= byte_en(mem_alu_operation, wb_read_address);
                        rd_q       <= wb_dest_reg_sel;
                        off_q      <= wb_read_address;
                        f3_q       <= mem_alu_operation;
                    end
                end
                S_REQ: begin
                    if (dmem_ready || timeout) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        dmem_be    <= '0;
                        if (dmem_ready && !dmem_we) begin
                            state <= S_LOAD_WAIT;
                        end else begin
                            state <= S_IDLE;
                            skip  <= 1'b1;
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    if (dmem_rvalid) begin
                        state <= S_IDLE;
                    end else if (timeout) begin
                        state <= S_IDLE;
                        skip  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (reset) begin
            if (state == S_LOAD_WAIT && dmem_rvalid && rd_q != 5'd0) begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = load_data;
            end else if (state == S_IDLE && live && wb_alu_to_reg && wb_dest_reg_sel != 5'd0) begin
                rf_we    = 1'b1;
                rf_waddr = wb_dest_reg_sel;
                rf_wdata = wb_result;
            end
        end
    end

    assign stall_read = reset && (start || (state == S_REQ) ||
                                  (state == S_LOAD_WAIT && !dmem_rvalid));
    assign misaligned = mis;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: vector table for single-cycle behaviour,
// hand sequences for loads, stores, reset mid-access and (optionally) timeout.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_result, wb_store_data, dmem_rdata;
    logic        wb_mem_write, wb_mem_to_reg, wb_alu_to_reg, wb_branch_nxt;
    logic [4:0]  wb_dest_reg_sel;
    logic [1:0]  wb_read_address;
    logic [2:0]  mem_alu_operation;
    logic        dmem_ready, dmem_rvalid;
    logic        dmem_req, dmem_we, rf_we, stall_read, misaligned, bus_error;
    logic [31:0] dmem_addr, dmem_wdata, rf_wdata;
    logic [3:0]  dmem_be;
    logic [4:0]  rf_waddr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_writeback #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .wb_result(wb_result), .wb_store_data(wb_store_data),
        .wb_mem_write(wb_mem_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_alu_to_reg(wb_alu_to_reg), .wb_dest_reg_sel(wb_dest_reg_sel),
        .wb_branch_nxt(wb_branch_nxt), .wb_read_address(wb_read_address),
        .mem_alu_operation(mem_alu_operation),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_read(stall_read), .misaligned(misaligned), .bus_error(bus_error)
    );

    typedef struct {
        string       name;
        logic        alu, mw, mr, bnxt;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] res;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_stall, e_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wb_result = '0; wb_store_data = '0; wb_mem_write = 0; wb_mem_to_reg = 0;
        wb_alu_to_reg = 0; wb_dest_reg_sel = '0; wb_branch_nxt = 0;
        wb_read_address = '0; mem_alu_operation = '0;
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = '0;
    endtask

    task automatic set_op(input logic alu, input logic mw, input logic mr, input logic bnxt,
                          input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] res, input logic [31:0] sdata);
        wb_alu_to_reg = alu; wb_mem_write = mw; wb_mem_to_reg = mr; wb_branch_nxt = bnxt;
        wb_dest_reg_sel = rd; mem_alu_operation = f3; wb_result = res;
        wb_read_address = res[1:0]; wb_store_data = sdata;
    endtask

    task automatic do_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        set_op(0, 0, 1, 0, rd, f3, addr, '0);
        dmem_ready = 1; dmem_rvalid = 1; dmem_rdata = rdata;
        @(negedge clk);
        chk({nm, " detect stall"}, stall_read, 1);
        chk({nm, " detect no write"}, rf_we, 0);
        tick();
        @(negedge clk);
        chk({nm, " req"}, dmem_req, 1);
        chk({nm, " we"}, dmem_we, 0);
        chk({nm, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({nm, " req stall"}, stall_read, 1);
        chk({nm, " req no write"}, rf_we, 0);
        tick();
        @(negedge clk);
        chk({nm, " rf_we"}, rf_we, 1);
        chk({nm, " rf_waddr"}, rf_waddr, rd);
        chk({nm, " rf_wdata"}, rf_wdata, exp);
        chk({nm, " done stall"}, stall_read, 0);
        tick();
        set_idle();
        @(negedge clk);
        chk({nm, " idle req"}, dmem_req, 0);
        tick();
    endtask

    task automatic do_store(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] sdata, input int delay,
                            input logic [3:0] e_be, input logic [31:0] e_wd);
        set_op(0, 1, 0, 0, 5'd0, f3, addr, sdata);
        dmem_ready = 0;
        @(negedge clk);
        chk({nm, " detect stall"}, stall_read, 1);
        chk({nm, " detect req"}, dmem_req, 0);
        tick();
        for (int k = 0; k <= delay; k++) begin
            dmem_ready = (k == delay);
            @(negedge clk);
            chk({nm, " req"}, dmem_req, 1);
            chk({nm, " we"}, dmem_we, 1);
            chk({nm, " addr"}, dmem_addr, {addr[31:2], 2'b00});
            chk({nm, " be"}, dmem_be, e_be);
            chk({nm, " wdata"}, dmem_wdata, e_wd);
            chk({nm, " req stall"}, stall_read, 1);
            tick();
        end
        dmem_ready = 0;
        // store still presented on wb_*: must not restart
        @(negedge clk);
        chk({nm, " after stall"}, stall_read, 0);
        chk({nm, " after req"}, dmem_req, 0);
        chk({nm, " after mis"}, misaligned, 0);
        tick();
        set_idle();
        @(negedge clk);
        chk({nm, " idle req"}, dmem_req, 0);
        tick();
    endtask

    initial begin
        vecs[0]  = '{"alu rd5",      1,0,0,0, 5'd5,  3'b000, 32'h0000_1234, 1, 5'd5,  32'h0000_1234, 0, 0};
        vecs[1]  = '{"alu rd0",      1,0,0,0, 5'd0,  3'b000, 32'h0000_1234, 0, 5'd0,  32'h0,         0, 0};
        vecs[2]  = '{"alu rd31",     1,0,0,0, 5'd31, 3'b000, 32'hDEAD_BEEF, 1, 5'd31, 32'hDEAD_BEEF, 0, 0};
        vecs[3]  = '{"alu squashed", 1,0,0,1, 5'd7,  3'b000, 32'h0000_0055, 0, 5'd0,  32'h0,         0, 0};
        vecs[4]  = '{"lw mis",       0,0,1,0, 5'd3,  3'b010, 32'h0000_0101, 0, 5'd0,  32'h0,         0, 1};
        vecs[5]  = '{"lw mis sq",    0,0,1,1, 5'd3,  3'b010, 32'h0000_0101, 0, 5'd0,  32'h0,         0, 0};
        vecs[6]  = '{"sw mis",       0,1,0,0, 5'd0,  3'b010, 32'h0000_0102, 0, 5'd0,  32'h0,         0, 1};
        vecs[7]  = '{"lh mis",       0,0,1,0, 5'd4,  3'b001, 32'h0000_0103, 0, 5'd0,  32'h0,         0, 1};
        vecs[8]  = '{"sh mis",       0,1,0,0, 5'd0,  3'b001, 32'h0000_0201, 0, 5'd0,  32'h0,         0, 1};
        vecs[9]  = '{"load f3 011",  0,0,1,0, 5'd6,  3'b011, 32'h0000_0100, 0, 5'd0,  32'h0,         0, 0};
        vecs[10] = '{"store f3 111", 0,1,0,0, 5'd0,  3'b111, 32'h0000_0100, 0, 5'd0,  32'h0,         0, 0};
        vecs[11] = '{"lhu mis",      0,0,1,0, 5'd8,  3'b101, 32'h0000_0103, 0, 5'd0,  32'h0,         0, 1};

        // Reset: outputs forced low even with an ALU op presented
        reset = 0;
        set_idle();
        set_op(1, 0, 0, 0, 5'd5, 3'b000, 32'h1234, '0);
        tick(); tick();
        @(negedge clk);
        chk("reset rf_we", rf_we, 0);
        chk("reset dmem_req", dmem_req, 0);
        chk("reset dmem_addr", dmem_addr, 0);
        chk("reset dmem_be", dmem_be, 0);
        chk("reset stall", stall_read, 0);
        chk("reset bus_error", bus_error, 0);
        tick();
        reset = 1;
        set_idle();
        tick();

        foreach (vecs[i]) begin
            set_op(vecs[i].alu, vecs[i].mw, vecs[i].mr, vecs[i].bnxt,
                   vecs[i].rd, vecs[i].f3, vecs[i].res, 32'h1111_2222);
            @(negedge clk);
            chk({vecs[i].name, " rf_we"}, rf_we, vecs[i].e_we);
            chk({vecs[i].name, " rf_waddr"}, rf_waddr, vecs[i].e_wa);
            chk({vecs[i].name, " rf_wdata"}, rf_wdata, vecs[i].e_wd);
            chk({vecs[i].name, " stall"}, stall_read, vecs[i].e_stall);
            chk({vecs[i].name, " misaligned"}, misaligned, vecs[i].e_mis);
            tick();
            set_idle();
            @(negedge clk);
            chk({vecs[i].name, " no req"}, dmem_req, 0);
            chk({vecs[i].name, " no pulse"}, misaligned, 0);
            tick();
        end

        do_load("lb 103",  32'h0000_0103, 3'b000, 5'd9,  32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu 103", 32'h0000_0103, 3'b100, 5'd9,  32'h80FF_0000, 32'h0000_0080);
        do_load("lh 102",  32'h0000_0102, 3'b001, 5'd10, 32'h80FF_0000, 32'hFFFF_80FF);
        do_load("lhu 102", 32'h0000_0102, 3'b101, 5'd10, 32'h80FF_0000, 32'h0000_80FF);
        do_load("lb 101",  32'h0000_0101, 3'b000, 5'd11, 32'h1234_5678, 32'h0000_0056);
        do_load("lw 100",  32'h0000_0100, 3'b010, 5'd12, 32'h1234_5678, 32'h1234_5678);

        do_store("sh 202",      32'h0000_0202, 3'b001, 32'h1234_ABCD, 0, 4'b1100, 32'hABCD_ABCD);
        do_store("sh 202 slow", 32'h0000_0202, 3'b001, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
        do_store("sb 301",      32'h0000_0301, 3'b000, 32'h0000_005A, 0, 4'b0010, 32'h5A5A_5A5A);
        do_store("sw 400",      32'h0000_0400, 3'b010, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);

        // Reset while waiting for load data; late rvalid must not write
        set_op(0, 0, 1, 0, 5'd4, 3'b010, 32'h0000_0600, '0);
        dmem_ready = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst-lw wait stall", stall_read, 1);
        reset = 0;
        #1;
        chk("rst-lw stall gated", stall_read, 0);
        tick();
        reset = 1;
        set_idle();
        dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst-lw req", dmem_req, 0);
        chk("rst-lw addr", dmem_addr, 0);
        chk("rst-lw be", dmem_be, 0);
        chk("rst-lw rf_we", rf_we, 0);
        chk("rst-lw stall", stall_read, 0);
        chk("rst-lw bus_error", bus_error, 0);
        tick();
        @(negedge clk);
        chk("rst-lw late rf_we", rf_we, 0);
        tick();
        set_idle();

`ifdef WB_TIMEOUT_EN
        // Load accepted but never answered: abort after 4 wait cycles
        set_op(0, 0, 1, 0, 5'd13, 3'b010, 32'h0000_0500, '0);
        dmem_ready = 1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to wait stall", stall_read, 1);
            chk("to wait bus_error", bus_error, 0);
            tick();
        end
        @(negedge clk);
        chk("to bus_error", bus_error, 1);
        chk("to rf_we", rf_we, 0);
        chk("to stall", stall_read, 0);
        chk("to req", dmem_req, 0);
        tick();
        set_idle();
        dmem_rvalid = 1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("to pulse end", bus_error, 0);
        chk("to late rf_we", rf_we, 0);
        tick();
        set_idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_writeback.md
# mem_writeback

Final stage of the 3-stage RV32 pipeline: consumes the EX→WB register outputs of `execute` (`wb_*`, `mem_alu_operation`) and completes each instruction. It drives the data-memory request/response handshake for loads and stores, aligns and extends load data, writes the register file, and back-pressures `execute` through `stall_read` while a memory access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 64, dmem wait cycles before abort (used only with `WB_TIMEOUT_EN`)
- `clk` in 1: clock
- `reset` in 1: synchronous, active-low
- `wb_result` in 32: ALU result, or effective address for load/store
- `wb_store_data` in 32: rs2 value for stores
- `wb_mem_write` in 1: store
- `wb_mem_to_reg` in 1: load
- `wb_alu_to_reg` in 1: ALU writeback
- `wb_dest_reg_sel` in 5: rd
- `wb_branch_nxt` in 1: instruction is in a taken-branch shadow; squash
- `wb_read_address` in 2: byte offset, equals `wb_result[1:0]`
- `mem_alu_operation` in 3: funct3 (load/store size and sign)
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (word aligned), `dmem_wdata` out 32, `dmem_be` out 4
- `dmem_ready` in 1: request accepted
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register-file write port
- `stall_read` out 1: hold EX/WB registers
- `misaligned` out 1: one-cycle pulse on misaligned access
- `bus_error` out 1: one-cycle pulse on timeout abort

## Operation
- States: IDLE, REQ, LOAD_WAIT. Reset (reset=0 at posedge): state IDLE, counter 0, every output 0.
- Instruction is live when `wb_branch_nxt`=0. Squashed instructions produce no request, no write, no pulse.
- ALU op (`wb_alu_to_reg`, live): `rf_we`=1, `rf_wdata`=`wb_result`, same cycle, no stall.
- rd=0: `rf_we` held 0 in every case.
- Load/store, live, in IDLE: misaligned if LH/LHU/SH with offset[0]=1, or LW/SW with offset≠0 → pulse `misaligned`, no request, no write, no stall.
- Otherwise IDLE→REQ at the next edge; `stall_read`=1 combinationally in the detecting IDLE cycle.
- REQ: `dmem_req`=1, `dmem_addr`={`wb_result`[31:2],2'b00}. Stores: `dmem_we`=1, data replicated per size (SB byte×4, SH half×2, SW word), `dmem_be` = SB 0001<<off, SH 0011<<off, SW 1111. On `dmem_ready`: store → IDLE, `stall_read` drops the cycle after; load → LOAD_WAIT.
- LOAD_WAIT: on `dmem_rvalid`: select byte/half at offset; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; `rf_we`=1 that cycle, `stall_read`=0 that cycle, → IDLE.
- funct3 011/110/111 on load or store: treated as no-op (no request, no write).
- `dmem_rvalid` in IDLE or REQ is ignored; `dmem_ready` outside REQ is ignored.
- Reset mid-access: return to IDLE; a late `dmem_rvalid` produces no write.

## Timing
- ALU writeback: 0 cycles (combinational from `wb_*`).
- Store: `stall_read` asserted for detect cycle + REQ cycles; minimum 2 cycles with `dmem_ready`=1 immediately.
- Load: minimum 3 cycles (detect, REQ, LOAD_WAIT with `rvalid`); each extra wait cycle adds one.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be` are stable from REQ entry until accepted.
- `misaligned`/`bus_error` are one-cycle pulses, never simultaneous.

## Configuration
- `WB_TIMEOUT_EN` defined: an 8-bit-minimum wait counter clears on REQ/LOAD_WAIT entry and increments each cycle in REQ or LOAD_WAIT; at `TIMEOUT_CYCLES` it pulses `bus_error`, drops `dmem_req`, performs no register-file write, and returns to IDLE. A handshake arriving in the same cycle as expiry wins.
- Not defined: no counter; waiting is unbounded; `bus_error` is tied to 0.

## Structure
- Shared package `pipe_pkg`: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum, and a byte-enable/alignment function shared with the EX stage's address logic.
- One sub-module, `load_align`: combinational byte/half select and sign/zero extension from `rdata`, offset, and funct3.

## Test plan
- ALU: `wb_alu_to_reg`=1, rd=5, result 0x1234 → same-cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `stall_read`=0; rd=0 → `rf_we`=0.
- LB at 0x103, rdata 0x80FF_0000 with `dmem_ready`/`rvalid` immediate → `dmem_addr`=0x100, `rf_wdata`=0xFFFF_FF80 on the 3rd cycle; LBU → 0x0000_0080.
- SH at 0x202, data 0xABCD → `dmem_be`=1100, `dmem_wdata`=0xABCD_ABCD, `stall_read` high for 2 cycles; `dmem_ready` delayed 3 cycles → signals held stable.
- LW at 0x101 → `misaligned` pulses, no `dmem_req`, no write; the same load with `wb_branch_nxt`=1 → nothing.
- With `WB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, load with no `rvalid` → `bus_error` pulses after 4 cycles, no write, back to IDLE; a late `rvalid` is ignored.
- Reset=0 asserted in LOAD_WAIT → all outputs 0 next cycle; subsequent `rvalid` → `rf_we` stays 0.
